// File: rtl/wb_spi_master.sv
// rtl/wb_spi_master.sv - Wishbone classic slave SPI master, single chip select, byte transfers
module wb_spi_master #(
    parameter logic [7:0] DEFAULT_DIV  = 8'd11,
    parameter logic       DEFAULT_CPOL = 1'b0,
    parameter logic       DEFAULT_CPHA = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        spi_cs0_n_o
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic [7:0]  div_q, div_d;
    logic        cs_q, cs_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  hp_q, hp_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        sample_q, sample_d;
    logic        miso_s1_q, miso_s2_q;

    logic        req, wr, rd, busy;
    logic [1:0]  reg_sel;
    logic [31:0] rdata;
    logic [7:0]  shift_in;
    logic        unused_bits;

    assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = req & wb_we_i;
    assign rd      = req & ~wb_we_i;
    assign reg_sel = wb_adr_i[3:2];
    assign busy    = (state_q == ST_SHIFT);

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:17], wb_sel_i[3]};

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign spi_sck_o   = sck_q;
    assign spi_mosi_o  = mosi_q;
    assign spi_cs0_n_o = ~cs_q;

    // Read mux; captured in the request cycle so data is valid alongside ack
    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            REG_CTRL:   rdata = {15'd0, cs_q, div_q, 6'd0, cpha_q, cpol_q};
            REG_STATUS: rdata = {29'd0, overrun_q, rx_valid_q, busy};
            REG_DATA:   rdata = {24'd0, rx_q};
            default:    rdata = 32'd0;
        endcase
    end

    // Bus decode and transfer FSM next-state; completion is evaluated last so it wins over a DATA read clear
    always_comb begin
        state_d    = state_q;
        ack_d      = req;
        dat_d      = dat_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        cs_d       = cs_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        rx_d       = rx_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        hp_d       = hp_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        sample_d   = sample_q;
        shift_in   = shift_q;

        if (rd) begin
            dat_d = rdata;
            if (reg_sel == REG_DATA) begin
                rx_valid_d = 1'b0;
            end
        end

        if (wr) begin
            case (reg_sel)
                REG_CTRL: begin
                    if (wb_sel_i[2]) cs_d = wb_dat_i[16];
                    if (!busy) begin
                        if (wb_sel_i[0]) begin
                            cpol_d = wb_dat_i[0];
                            cpha_d = wb_dat_i[1];
                        end
                        if (wb_sel_i[1]) div_d = wb_dat_i[15:8];
                    end
                end
                REG_STATUS: begin
                    if (wb_sel_i[0] && wb_dat_i[2]) overrun_d = 1'b0;
                end
                REG_DATA: begin
                    if (wb_sel_i[0]) begin
                        if (busy) begin
                            overrun_d = 1'b1;
                        end else begin
                            shift_d = wb_dat_i[7:0];
                            mosi_d  = wb_dat_i[7];
                            cnt_d   = 8'd0;
                            hp_d    = 4'd0;
                            state_d = ST_SHIFT;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                sck_d = cpol_d;
            end
            ST_SHIFT: begin
                if (cnt_q == div_q) begin
                    cnt_d = 8'd0;
                    sck_d = ~sck_q;
                    hp_d  = hp_q + 4'd1;
                    if (!hp_q[0]) begin
                        // leading edge
                        if (!cpha_q) sample_d = miso_s2_q;
                        else         mosi_d   = shift_q[7];
                    end else begin
                        // trailing edge
                        shift_in = {shift_q[6:0], (cpha_q ? miso_s2_q : sample_q)};
                        shift_d  = shift_in;
                        if (!cpha_q) mosi_d = shift_q[6];
                        if (hp_q == 4'd15) begin
                            state_d    = ST_IDLE;
                            rx_d       = shift_in;
                            rx_valid_d = 1'b1;
                            sck_d      = cpol_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous abort to reset values
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            cpol_q     <= DEFAULT_CPOL;
            cpha_q     <= DEFAULT_CPHA;
            div_q      <= DEFAULT_DIV;
            cs_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            rx_q       <= 8'd0;
            shift_q    <= 8'd0;
            cnt_q      <= 8'd0;
            hp_q       <= 4'd0;
            sck_q      <= DEFAULT_CPOL;
            mosi_q     <= 1'b0;
            sample_q   <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            cs_q       <= cs_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            rx_q       <= rx_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            hp_q       <= hp_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            sample_q   <= sample_d;
            miso_s1_q  <= spi_miso_i;
            miso_s2_q  <= miso_s1_q;
        end
    end

endmodule

// File: tb/tb_wb_spi_master.sv
// tb/tb_wb_spi_master.sv - directed self-checking bench for wb_spi_master
module tb_wb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [31:0] dat_o;
    logic        ack;
    logic        sck, mosi, cs_n;
    logic        miso = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_spi_master dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_i),
        .wb_sel_i    (sel),
        .wb_we_i     (we),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_dat_o    (dat_o),
        .wb_ack_o    (ack),
        .spi_sck_o   (sck),
        .spi_mosi_o  (mosi),
        .spi_miso_i  (miso),
        .spi_cs0_n_o (cs_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // SPI slave model: shifts s_tx out on MISO and collects MOSI into s_rx
    logic       tb_cpol = 1'b0;
    logic       tb_cpha = 1'b0;
    logic [7:0] s_load_byte = 8'd0;
    logic       s_load_req = 1'b0;
    logic       s_load_seen = 1'b0;
    logic [7:0] s_tx = 8'd0;
    logic [7:0] s_rx = 8'd0;
    logic       sck_prev = 1'b0;

    always @(sck or s_load_req) begin
        if (s_load_req != s_load_seen) begin
            s_load_seen = s_load_req;
            s_tx = s_load_byte;
            s_rx = 8'd0;
            miso = tb_cpha ? 1'b0 : s_load_byte[7];
        end else if (sck !== sck_prev) begin
            if (sck != tb_cpol) begin
                if (!tb_cpha) s_rx = {s_rx[6:0], mosi};
                else begin
                    miso = s_tx[7];
                    s_tx = s_tx << 1;
                end
            end else begin
                if (!tb_cpha) begin
                    s_tx = s_tx << 1;
                    miso = s_tx[7];
                end else s_rx = {s_rx[6:0], mosi};
            end
        end
        sck_prev = sck;
    end

    // SCK pulse monitor: counts rising edges and high pulses not exactly 3 cycles long
    int   rises = 0;
    int   bad_pulse = 0;
    int   hi_run = 0;
    logic sck_d1 = 1'b0;

    always @(negedge clk) begin
        if (sck === 1'b1) hi_run++;
        if (sck === 1'b1 && sck_d1 === 1'b0) rises++;
        if (sck === 1'b0 && sck_d1 === 1'b1 && hi_run != 3) bad_pulse++;
        if (sck !== 1'b1) hi_run = 0;
        sck_d1 = sck;
    end

    task automatic slave_load(input logic [7:0] b);
        s_load_byte = b;
        s_load_req  = ~s_load_req;
        #1;
    endtask

    // One Wishbone classic cycle; call at a negedge, returns at the negedge where ack is seen
    task automatic wb_op(input logic w, input logic [3:0] a, input logic [31:0] d,
                         output logic [31:0] r);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== 1'b1 && n < 8);
        if (ack !== 1'b1) chk("ack_timeout", {31'd0, ack}, 32'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_op(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_op(1'b0, a, 32'd0, r);
        chk(tag, r, exp);
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        int n;
        n = 0;
        do begin
            wb_op(1'b0, 4'h4, 32'd0, r);
            n++;
        end while (r[0] && n < 200);
        chk("busy_clear", {31'd0, r[0]}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] m_tx [3] = '{8'h96, 8'h4B, 8'hE1};
    logic [7:0] m_rx [3] = '{8'h3C, 8'hC5, 8'h7E};

    initial begin
        int r0, b0;
        rst_n = 1'b0; adr = 4'h0; dat_i = 32'd0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_sck",  {31'd0, sck},  32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_ack",  {31'd0, ack},  32'd0);
        chk("rst_dat",  dat_o, 32'd0);
        rd_chk("rst_ctrl",   4'h0, 32'h0000_0B00);
        rd_chk("rst_status", 4'h4, 32'h0000_0000);

        // mode 0, div 2, 0xA5 out / 0x3C in
        wr(4'h0, 32'h0001_0200);
        chk("cs_low", {31'd0, cs_n}, 32'd0);
        tb_cpol = 1'b0; tb_cpha = 1'b0;
        slave_load(8'h3C);
        @(negedge clk);
        r0 = rises; b0 = bad_pulse;
        wr(4'h8, 32'h0000_00A5);
        repeat (47) @(negedge clk);
        rd_chk("m0_busy_last", 4'h4, 32'h1);
        rd_chk("m0_done_stat", 4'h4, 32'h2);
        chk("m0_rises", rises - r0, 32'd8);
        chk("m0_pulse_len", bad_pulse - b0, 32'd0);
        chk("m0_mosi", {24'd0, s_rx}, 32'hA5);
        rd_chk("m0_rx", 4'h8, 32'h3C);
        rd_chk("m0_stat_clr", 4'h4, 32'h0);

        // modes 1..3 at div 3
        for (int m = 1; m < 4; m++) begin
            tb_cpol = m[1]; tb_cpha = m[0];
            wr(4'h0, {15'd0, 1'b1, 8'd3, 6'd0, tb_cpha, tb_cpol});
            @(negedge clk);
            chk($sformatf("m%0d_idle_sck", m), {31'd0, sck}, {31'd0, tb_cpol});
            slave_load(m_rx[m-1]);
            wr(4'h8, {24'd0, m_tx[m-1]});
            wait_idle();
            chk($sformatf("m%0d_end_sck", m), {31'd0, sck}, {31'd0, tb_cpol});
            chk($sformatf("m%0d_mosi", m), {24'd0, s_rx}, {24'd0, m_tx[m-1]});
            rd_chk($sformatf("m%0d_rx", m), 4'h8, {24'd0, m_rx[m-1]});
        end

        // overrun: second write while busy is dropped
        wr(4'h0, 32'h0001_0200);
        tb_cpol = 1'b0; tb_cpha = 1'b0;
        @(negedge clk);
        slave_load(8'h00);
        wr(4'h8, 32'h11);
        wr(4'h8, 32'h22);
        rd_chk("ovr_stat_busy", 4'h4, 32'h5);
        wait_idle();
        rd_chk("ovr_stat_end", 4'h4, 32'h6);
        chk("ovr_mosi", {24'd0, s_rx}, 32'h11);
        wr(4'h4, 32'h4);
        rd_chk("ovr_cleared", 4'h4, 32'h2);
        rd_chk("ovr_rx", 4'h8, 32'h00);

        // asynchronous reset at hp=7
        slave_load(8'h81);
        wr(4'h8, 32'hFF);
        repeat (21) @(negedge clk);
        chk("pre_rst_sck", {31'd0, sck}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("arst_sck",  {31'd0, sck},  32'd0);
        chk("arst_mosi", {31'd0, mosi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("arst_ctrl",   4'h0, 32'h0000_0B00);
        rd_chk("arst_status", 4'h4, 32'h0);
        rd_chk("arst_rx",     4'h8, 32'h0);
        wr(4'h0, 32'h0001_0200);
        slave_load(8'hC3);
        wr(4'h8, 32'h5A);
        wait_idle();
        chk("post_rst_mosi", {24'd0, s_rx}, 32'h5A);
        rd_chk("post_rst_rx", 4'h8, 32'hC3);

        // DATA read in the completion cycle
        slave_load(8'h99);
        wr(4'h8, 32'h33);
        repeat (47) @(negedge clk);
        rd_chk("cmp_old_rx", 4'h8, 32'hC3);
        rd_chk("cmp_valid_kept", 4'h4, 32'h2);
        rd_chk("cmp_new_rx", 4'h8, 32'h99);
        rd_chk("cmp_stat_clr", 4'h4, 32'h0);
        chk("cmp_mosi", {24'd0, s_rx}, 32'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
